// File: rtl/vga_timing_pkg.sv
// Shared constants for the VGA raster timing generator.
// Holds the default 640x480@60 geometry, the matching coordinate width,
// and a helper that sums the four segments of one axis.
package vga_timing_pkg;

   localparam int unsigned DEF_H_ACTIVE = 640;
   localparam int unsigned DEF_H_FP     = 16;
   localparam int unsigned DEF_H_SYNC   = 96;
   localparam int unsigned DEF_H_BP     = 48;
   localparam int unsigned DEF_V_ACTIVE = 480;
   localparam int unsigned DEF_V_FP     = 10;
   localparam int unsigned DEF_V_SYNC   = 2;
   localparam int unsigned DEF_V_BP     = 33;
   localparam int unsigned DEF_CW       = 10;

   // Total length of one axis (line or frame) in counter steps.
   function automatic int unsigned axis_total(input int unsigned active,
                                              input int unsigned fp,
                                              input int unsigned sync,
                                              input int unsigned bp);
      return active + fp + sync + bp;
   endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter plus registered active/sync flags.
// Segment order along the axis is active, front porch, sync, back porch.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   inc         - advance the position by one this cycle
//   pos         - registered position, 0..TOTAL-1 (resets to TOTAL-1)
//   active      - registered, pos inside the active segment
//   sync        - registered sync level, POL while pos is in the sync segment
//   wrap_next   - combinational, pos is TOTAL-1 (next advance wraps to 0)
module vga_axis_counter
   import vga_timing_pkg::*;
#(
   parameter int unsigned ACTIVE = DEF_H_ACTIVE,
   parameter int unsigned FP     = DEF_H_FP,
   parameter int unsigned SYNC   = DEF_H_SYNC,
   parameter int unsigned BP     = DEF_H_BP,
   parameter bit          POL    = 1'b0,
   parameter int unsigned CW     = DEF_CW
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          inc,
   output logic [CW-1:0] pos,
   output logic          active,
   output logic          sync,
   output logic          wrap_next
);

   localparam int unsigned   TOTAL      = axis_total(ACTIVE, FP, SYNC, BP);
   localparam logic [CW-1:0] LAST       = CW'(TOTAL - 1);
   localparam logic [CW-1:0] ACT_END    = CW'(ACTIVE);
   localparam logic [CW-1:0] SYNC_BEGIN = CW'(ACTIVE + FP);
   localparam logic [CW-1:0] SYNC_END   = CW'(ACTIVE + FP + SYNC);

   logic [CW-1:0] pos_q, pos_d;
   logic          active_q, active_d;
   logic          sync_q, sync_d;

   assign wrap_next = (pos_q == LAST);

   // Flags are decoded from the next position so they line up with pos.
   always_comb begin
      pos_d = pos_q;
      if (inc) begin
         pos_d = wrap_next ? '0 : pos_q + CW'(1);
      end
      active_d = (pos_d < ACT_END);
      sync_d   = ((pos_d >= SYNC_BEGIN) && (pos_d < SYNC_END)) ? POL : ~POL;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pos_q    <= LAST;
         active_q <= 1'b0;
         sync_q   <= ~POL;
      end else begin
         pos_q    <= pos_d;
         active_q <= active_d;
         sync_q   <= sync_d;
      end
   end

   assign pos    = pos_q;
   assign active = active_q;
   assign sync   = sync_q;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator. Counts pixel clock-enables into line/frame
// coordinates and produces sync, data-enable and line/frame start pulses.
// Ports:
//   clk, rst_n   - system clock, asynchronous active-low reset
//   pix_ce       - pixel clock-enable; counters advance only when high
//   h_sync       - horizontal sync, active level H_SYNC_POL
//   v_sync       - vertical sync, active level V_SYNC_POL
//   de           - high inside the visible region
//   h_pos, v_pos - current column / line
//   line_start   - one-clk pulse on advance to h_pos = 0
//   frame_start  - one-clk pulse on advance to (0,0)
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int unsigned H_ACTIVE   = DEF_H_ACTIVE,
   parameter int unsigned H_FP       = DEF_H_FP,
   parameter int unsigned H_SYNC     = DEF_H_SYNC,
   parameter int unsigned H_BP       = DEF_H_BP,
   parameter int unsigned V_ACTIVE   = DEF_V_ACTIVE,
   parameter int unsigned V_FP       = DEF_V_FP,
   parameter int unsigned V_SYNC     = DEF_V_SYNC,
   parameter int unsigned V_BP       = DEF_V_BP,
   parameter bit          H_SYNC_POL = 1'b0,
   parameter bit          V_SYNC_POL = 1'b0,
   parameter int unsigned CW         = DEF_CW
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          pix_ce,
   output logic          h_sync,
   output logic          v_sync,
   output logic          de,
   output logic [CW-1:0] h_pos,
   output logic [CW-1:0] v_pos,
   output logic          line_start,
   output logic          frame_start
);

   logic h_active, v_active;
   logic h_wrap, v_wrap;
   logic v_inc;
   logic line_start_q, line_start_d;
   logic frame_start_q, frame_start_d;

   // The vertical axis steps only on the pixel that wraps the line.
   assign v_inc = pix_ce & h_wrap;

   vga_axis_counter #(
      .ACTIVE (H_ACTIVE),
      .FP     (H_FP),
      .SYNC   (H_SYNC),
      .BP     (H_BP),
      .POL    (H_SYNC_POL),
      .CW     (CW)
   ) u_h_axis (
      .clk       (clk),
      .rst_n     (rst_n),
      .inc       (pix_ce),
      .pos       (h_pos),
      .active    (h_active),
      .sync      (h_sync),
      .wrap_next (h_wrap)
   );

   vga_axis_counter #(
      .ACTIVE (V_ACTIVE),
      .FP     (V_FP),
      .SYNC   (V_SYNC),
      .BP     (V_BP),
      .POL    (V_SYNC_POL),
      .CW     (CW)
   ) u_v_axis (
      .clk       (clk),
      .rst_n     (rst_n),
      .inc       (v_inc),
      .pos       (v_pos),
      .active    (v_active),
      .sync      (v_sync),
      .wrap_next (v_wrap)
   );

   always_comb begin
      line_start_d  = v_inc;
      frame_start_d = v_inc & v_wrap;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
      end
   end

   // Both terms are flop outputs, so de carries no path from pix_ce.
   assign de          = h_active & v_active;
   assign line_start  = line_start_q;
   assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: a default 640x480 instance (a) and a
// tiny 5x5 instance (b) share clock and reset with independent pix_ce.
module tb_vga_timing_gen;

   logic clk = 1'b0;
   logic rst_n;
   logic ce_a, ce_b;

   logic       hs_a, vs_a, de_a, ls_a, fs_a;
   logic [9:0] hp_a, vp_a;
   logic       hs_b, vs_b, de_b, ls_b, fs_b;
   logic [2:0] hp_b, vp_b;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   vga_timing_gen dut_a (
      .clk         (clk),
      .rst_n       (rst_n),
      .pix_ce      (ce_a),
      .h_sync      (hs_a),
      .v_sync      (vs_a),
      .de          (de_a),
      .h_pos       (hp_a),
      .v_pos       (vp_a),
      .line_start  (ls_a),
      .frame_start (fs_a)
   );

   vga_timing_gen #(
      .H_ACTIVE   (2), .H_FP (1), .H_SYNC (1), .H_BP (1),
      .V_ACTIVE   (2), .V_FP (1), .V_SYNC (1), .V_BP (1),
      .H_SYNC_POL (1'b1),
      .CW         (3)
   ) dut_b (
      .clk         (clk),
      .rst_n       (rst_n),
      .pix_ce      (ce_b),
      .h_sync      (hs_b),
      .v_sync      (vs_b),
      .de          (de_b),
      .h_pos       (hp_b),
      .v_pos       (vp_b),
      .line_start  (ls_b),
      .frame_start (fs_b)
   );

   typedef struct packed {
      int h;
      int v;
      bit ls;
      bit fs;
   } mstate_t;

   mstate_t ma, mb;

   function automatic mstate_t reset_state(input int ht, input int vt);
      mstate_t s;
      s.h  = ht - 1;
      s.v  = vt - 1;
      s.ls = 1'b0;
      s.fs = 1'b0;
      return s;
   endfunction

   // Reference raster: one pix_ce moves one pixel; pulses mark the advance.
   function automatic mstate_t adv(input mstate_t s, input bit ce, input int ht,
                                   input int vt);
      mstate_t n = s;
      n.ls = 1'b0;
      n.fs = 1'b0;
      if (ce) begin
         if (s.h == ht - 1) begin
            n.h  = 0;
            n.ls = 1'b1;
            if (s.v == vt - 1) begin
               n.v  = 0;
               n.fs = 1'b1;
            end else begin
               n.v = s.v + 1;
            end
         end else begin
            n.h = s.h + 1;
         end
      end
      return n;
   endfunction

   task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      cmp("a_h_pos", 32'(hp_a), ma.h);
      cmp("a_v_pos", 32'(vp_a), ma.v);
      cmp("a_de", 32'(de_a), 32'(ma.h < 640 && ma.v < 480));
      cmp("a_h_sync", 32'(hs_a), 32'((ma.h >= 656 && ma.h < 752) ? 0 : 1));
      cmp("a_v_sync", 32'(vs_a), 32'((ma.v >= 490 && ma.v < 492) ? 0 : 1));
      cmp("a_line_start", 32'(ls_a), 32'(ma.ls));
      cmp("a_frame_start", 32'(fs_a), 32'(ma.fs));
      cmp("b_h_pos", 32'(hp_b), mb.h);
      cmp("b_v_pos", 32'(vp_b), mb.v);
      cmp("b_de", 32'(de_b), 32'(mb.h < 2 && mb.v < 2));
      cmp("b_h_sync", 32'(hs_b), 32'((mb.h == 3) ? 1 : 0));
      cmp("b_v_sync", 32'(vs_b), 32'((mb.v == 3) ? 0 : 1));
      cmp("b_line_start", 32'(ls_b), 32'(mb.ls));
      cmp("b_frame_start", 32'(fs_b), 32'(mb.fs));
   endtask

   // Drive enables, take one edge, sample 1 ns later against the model.
   task automatic step(input bit a, input bit b);
      ce_a = a;
      ce_b = b;
      @(posedge clk);
      #1;
      ma = adv(ma, a, 800, 525);
      mb = adv(mb, b, 5, 5);
      check_all();
   endtask

   initial begin
      int cnt, de_cnt, hs_cnt, hs_first, hs_last;
      bit seen;

      rst_n = 1'b0;
      ce_a  = 1'b0;
      ce_b  = 1'b0;
      ma    = reset_state(800, 525);
      mb    = reset_state(5, 5);

      // Reset state.
      repeat (3) @(posedge clk);
      #1;
      cmp("rst_h_pos", 32'(hp_a), 799);
      cmp("rst_v_pos", 32'(vp_a), 524);
      cmp("rst_h_sync", 32'(hs_a), 1);
      cmp("rst_de", 32'(de_a), 0);
      cmp("rst_b_h_sync", 32'(hs_b), 0);
      check_all();

      // Release mid-cycle; outputs hold without pix_ce.
      #2 rst_n = 1'b1;
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);

      // First pix_ce lands on (0,0) with both pulses.
      step(1'b1, 1'b1);
      cmp("first_h_pos", 32'(hp_a), 0);
      cmp("first_v_pos", 32'(vp_a), 0);
      cmp("first_de", 32'(de_a), 1);
      cmp("first_line_start", 32'(ls_a), 1);
      cmp("first_frame_start", 32'(fs_a), 1);
      step(1'b0, 1'b0);
      cmp("idle_line_start", 32'(ls_a), 0);

      // Tiny geometry: two full frames up to (4,4), then wrap to (0,0).
      repeat (49) step(1'b0, 1'b1);
      cmp("tiny_h_end", 32'(hp_b), 4);
      cmp("tiny_v_end", 32'(vp_b), 4);
      step(1'b0, 1'b1);
      cmp("tiny_wrap_h", 32'(hp_b), 0);
      cmp("tiny_wrap_v", 32'(vp_b), 0);
      cmp("tiny_wrap_frame", 32'(fs_b), 1);
      cmp("tiny_wrap_de", 32'(de_b), 1);

      // Default geometry, full rate: one line between line_start pulses.
      cnt      = 0;
      de_cnt   = 0;
      hs_cnt   = 0;
      hs_first = -1;
      hs_last  = -1;
      seen     = 1'b0;
      while (!seen && cnt < 2000) begin
         step(1'b1, 1'b0);
         cnt++;
         de_cnt += int'(de_a);
         if (!hs_a) begin
            hs_cnt++;
            if (hs_first < 0) hs_first = int'(hp_a);
            hs_last = int'(hp_a);
         end
         seen = ls_a;
      end
      cmp("line_period", cnt, 800);
      cmp("line_de_count", de_cnt, 640);
      cmp("line_hsync_count", hs_cnt, 96);
      cmp("hsync_first", hs_first, 656);
      cmp("hsync_last", hs_last, 751);

      // Half rate: 800 enables plus 799 idle clocks to the next pulse.
      cnt  = 0;
      seen = 1'b0;
      while (!seen && cnt < 4000) begin
         step(1'b1, 1'b0);
         cnt++;
         if (ls_a) seen = 1'b1;
         else begin
            step(1'b0, 1'b0);
            cnt++;
         end
      end
      cmp("half_rate_period", cnt, 1599);
      step(1'b0, 1'b0);
      cmp("half_rate_pulse_width", 32'(ls_a), 0);

      // Asynchronous reset mid-frame at (300,2).
      repeat (300) step(1'b1, 1'b0);
      cmp("pre_rst_h_pos", 32'(hp_a), 300);
      cmp("pre_rst_v_pos", 32'(vp_a), 2);
      #3 rst_n = 1'b0;
      #1;
      ma = reset_state(800, 525);
      mb = reset_state(5, 5);
      cmp("async_h_pos", 32'(hp_a), 799);
      cmp("async_v_pos", 32'(vp_a), 524);
      cmp("async_de", 32'(de_a), 0);
      cmp("async_h_sync", 32'(hs_a), 1);
      check_all();
      @(posedge clk);
      #3 rst_n = 1'b1;
      step(1'b0, 1'b0);
      step(1'b1, 1'b1);
      cmp("restart_h_pos", 32'(hp_a), 0);
      cmp("restart_v_pos", 32'(vp_a), 0);
      cmp("restart_frame_start", 32'(fs_a), 1);

      // Sparse random enables (~30%) checked against the model every cycle.
      for (int i = 0; i < 1200; i++) begin
         step($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 30);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
